// File: rtl/sp_ram_gen.sv
// Parametrised single-port synchronous RAM with a built-in clear sequencer.
// Optional per-word parity is enabled by defining SP_RAM_PARITY_EN.
module sp_ram_gen #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8,
  parameter int READ_MODE = 0,
  parameter int WRITE_MODE = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              oce,
  input  logic              wre,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_req,
  input  logic              perr_inj,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              perr
);

`ifdef SP_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;
  logic              busy_q;
  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic [MEM_W-1:0]  run_word;
  logic [MEM_W-1:0]  clr_word;
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  s1_word_d;
  logic              s1_load_d;
  logic              s1_perr_d;
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_perr_q;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_ad;
  logic [MEM_W-1:0]  mem_wd;
  logic              unused_oce;

  assign unused_oce = oce;

`ifdef SP_RAM_PARITY_EN
  assign run_word = {(^din) ^ perr_inj, din};
  assign clr_word = {^CLEAR_VAL, CLEAR_VAL};
`else
  logic unused_perr_inj;
  assign unused_perr_inj = perr_inj;
  assign run_word = din;
  assign clr_word = CLEAR_VAL;
`endif

  assign cnt_d = cnt_q + 1'b1;
  assign busy  = busy_q;

  // Clear sequencer; the counter MSB flags that the last address was written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_req) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d[ADDR_W]) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          if (clr_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign mem_we = busy_q ? 1'b1 : (ce & wre);
  assign mem_ad = busy_q ? cnt_q[ADDR_W-1:0] : ad;
  assign mem_wd = busy_q ? clr_word : run_word;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_ad] <= mem_wd;
  end

  assign rd_word = mem_q[ad];

  // Reads and the WRITE_MODE dout effect share the same first output stage.
  always_comb begin
    s1_load_d = 1'b0;
    s1_word_d = rd_word;
    if (!busy_q && ce) begin
      if (!wre) begin
        s1_load_d = 1'b1;
      end else if (WRITE_MODE == 1) begin
        s1_load_d = 1'b1;
        s1_word_d = run_word;
      end else if (WRITE_MODE == 2) begin
        s1_load_d = 1'b1;
      end
    end
  end

`ifdef SP_RAM_PARITY_EN
  assign s1_perr_d = ^s1_word_d;
`else
  assign s1_perr_d = 1'b0;
`endif

  // Stage 1: registered array read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_data_q <= '0;
      s1_perr_q <= 1'b0;
    end else if (s1_load_d) begin
      s1_data_q <= s1_word_d[DATA_W-1:0];
      s1_perr_q <= s1_perr_d;
    end
  end

  generate
    if (READ_MODE == 1) begin : g_pipe
      logic [DATA_W-1:0] out_data_q;
      logic              out_perr_q;
      // Stage 2: output register, frozen while the clear sequencer runs
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_data_q <= '0;
          out_perr_q <= 1'b0;
        end else if (oce && !busy_q) begin
          out_data_q <= s1_data_q;
          out_perr_q <= s1_perr_q;
        end
      end
      assign dout = out_data_q;
      assign perr = out_perr_q;
    end else begin : g_byp
      assign dout = s1_data_q;
      assign perr = s1_perr_q;
    end
  endgenerate

endmodule

// File: tb/tb_sp_ram_gen.sv
// Directed self-checking bench for sp_ram_gen: four instances cover
// READ_MODE 0 with WRITE_MODE 0/1/2 and READ_MODE 1 with WRITE_MODE 0.
module tb_sp_ram_gen;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce, oce, wre, clr_req, perr_inj;
  logic [7:0] ad;
  logic [3:0] din;
  logic [3:0] dout_a [4];
  logic       busy_a [4];
  logic       perr_a [4];
  int         n_chk = 0;
  int         n_fail = 0;

`ifdef SP_RAM_PARITY_EN
  localparam logic EXP_INJ_PERR = 1'b1;
`else
  localparam logic EXP_INJ_PERR = 1'b0;
`endif

  always #5 clk = ~clk;

  sp_ram_gen #(.DATA_W(4), .ADDR_W(8), .READ_MODE(0), .WRITE_MODE(0), .CLEAR_VAL(4'hA)) u_w0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .clr_req(clr_req), .perr_inj(perr_inj), .dout(dout_a[0]), .busy(busy_a[0]), .perr(perr_a[0]));
  sp_ram_gen #(.DATA_W(4), .ADDR_W(8), .READ_MODE(0), .WRITE_MODE(1), .CLEAR_VAL(4'hA)) u_w1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .clr_req(clr_req), .perr_inj(perr_inj), .dout(dout_a[1]), .busy(busy_a[1]), .perr(perr_a[1]));
  sp_ram_gen #(.DATA_W(4), .ADDR_W(8), .READ_MODE(0), .WRITE_MODE(2), .CLEAR_VAL(4'hA)) u_w2 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .clr_req(clr_req), .perr_inj(perr_inj), .dout(dout_a[2]), .busy(busy_a[2]), .perr(perr_a[2]));
  sp_ram_gen #(.DATA_W(4), .ADDR_W(8), .READ_MODE(1), .WRITE_MODE(0), .CLEAR_VAL(4'hA)) u_p0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .clr_req(clr_req), .perr_inj(perr_inj), .dout(dout_a[3]), .busy(busy_a[3]), .perr(perr_a[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] d, input logic inj);
    ce = 1'b1; wre = 1'b1; ad = a; din = d; perr_inj = inj;
    step();
    ce = 1'b0; wre = 1'b0; perr_inj = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    ce = 1'b1; wre = 1'b0; ad = a;
    step();
    ce = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy_a[0] && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] addrs [3];
    addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
    step(); step();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (busy_a[i] !== 1'b1 || dout_a[i] !== 4'h0 || perr_a[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d busy=%b dout=%h perr=%b exp 1/0/0", i, busy_a[i], dout_a[i], perr_a[i]);
      end
    end
    reset_n = 1'b1;
    count_busy(n);
    n_chk++;
    if (n !== 256) begin
      n_fail++;
      $display("FAIL clear_len got=%0d exp=256", n);
    end
    for (int i = 1; i < 4; i++) begin
      n_chk++;
      if (busy_a[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_fall inst%0d got=%b exp=0", i, busy_a[i]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      rd(addrs[k]);
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (dout_a[i] !== 4'hA) begin
          n_fail++;
          $display("FAIL clear_val inst%0d addr=%h got=%h exp=a", i, addrs[k], dout_a[i]);
        end
      end
      step();
      n_chk++;
      if (dout_a[3] !== 4'hA) begin
        n_fail++;
        $display("FAIL clear_val_pipe addr=%h got=%h exp=a", addrs[k], dout_a[3]);
      end
    end
  endtask

  task automatic test_rw();
    wr(8'h12, 4'h5, 1'b0);
    n_chk++;
    if (dout_a[0] !== 4'hA || dout_a[1] !== 4'h5 || dout_a[2] !== 4'hA) begin
      n_fail++;
      $display("FAIL write_dout got=%h/%h/%h exp=a/5/a", dout_a[0], dout_a[1], dout_a[2]);
    end
    rd(8'h12);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (dout_a[i] !== 4'h5) begin
        n_fail++;
        $display("FAIL readback inst%0d got=%h exp=5", i, dout_a[i]);
      end
    end
    step();
    n_chk++;
    if (dout_a[3] !== 4'h5) begin
      n_fail++;
      $display("FAIL readback_pipe got=%h exp=5", dout_a[3]);
    end
  endtask

  task automatic test_write_modes();
    wr(8'h30, 4'h3, 1'b0);
    n_chk++;
    if (dout_a[1] !== 4'h3 || dout_a[2] !== 4'hA) begin
      n_fail++;
      $display("FAIL wmode_first got=%h/%h exp=3/a", dout_a[1], dout_a[2]);
    end
    wr(8'h30, 4'hC, 1'b0);
    n_chk++;
    if (dout_a[0] !== 4'h5 || dout_a[1] !== 4'hC || dout_a[2] !== 4'h3) begin
      n_fail++;
      $display("FAIL wmode_second got=%h/%h/%h exp=5/c/3", dout_a[0], dout_a[1], dout_a[2]);
    end
    rd(8'h30);
    step();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (dout_a[i] !== 4'hC) begin
        n_fail++;
        $display("FAIL wmode_readback inst%0d got=%h exp=c", i, dout_a[i]);
      end
    end
  endtask

  task automatic test_pipeline();
    oce = 1'b0;
    rd(8'h12);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (dout_a[3] !== 4'hC) begin
        n_fail++;
        $display("FAIL oce_hold cyc%0d got=%h exp=c", k, dout_a[3]);
      end
      if (k < 2) step();
    end
    oce = 1'b1;
    step();
    n_chk++;
    if (dout_a[3] !== 4'h5) begin
      n_fail++;
      $display("FAIL oce_load got=%h exp=5", dout_a[3]);
    end
    for (int k = 0; k < 4; k++) wr(8'h40 + 8'(k), 4'(k + 1), 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        ce = 1'b1; wre = 1'b0; ad = 8'h40 + 8'(k);
      end else begin
        ce = 1'b0;
      end
      step();
      if (k < 4) begin
        n_chk++;
        if (dout_a[0] !== 4'(k + 1)) begin
          n_fail++;
          $display("FAIL b2b_byp k=%0d got=%h exp=%h", k, dout_a[0], 4'(k + 1));
        end
      end
      if (k >= 1) begin
        n_chk++;
        if (dout_a[3] !== 4'(k)) begin
          n_fail++;
          $display("FAIL b2b_pipe k=%0d got=%h exp=%h", k, dout_a[3], 4'(k));
        end
      end
    end
  endtask

  task automatic test_clr_restart();
    int n;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (50) step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    count_busy(n);
    n_chk++;
    if (n !== 256) begin
      n_fail++;
      $display("FAIL clr_restart_len got=%0d exp=256", n);
    end
    wr(8'h12, 4'h5, 1'b0);
    rd(8'h12);
    n_chk++;
    if (dout_a[0] !== 4'h5) begin
      n_fail++;
      $display("FAIL rewrite got=%h exp=5", dout_a[0]);
    end
  endtask

  task automatic test_clear_reset();
    int n;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n_chk++;
    if (busy_a[0] !== 1'b1 || busy_a[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_busy got=%b/%b exp=1/1", busy_a[0], busy_a[3]);
    end
    ce = 1'b1; wre = 1'b0; ad = 8'h00;
    repeat (100) step();
    ce = 1'b0;
    n_chk++;
    if (dout_a[0] !== 4'h5) begin
      n_fail++;
      $display("FAIL busy_hold got=%h exp=5", dout_a[0]);
    end
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (busy_a[i] !== 1'b1 || dout_a[i] !== 4'h0) begin
        n_fail++;
        $display("FAIL async_reset inst%0d busy=%b dout=%h exp 1/0", i, busy_a[i], dout_a[i]);
      end
    end
    step();
    reset_n = 1'b1;
    count_busy(n);
    n_chk++;
    if (n !== 256) begin
      n_fail++;
      $display("FAIL reclear_len got=%0d exp=256", n);
    end
    rd(8'h12);
    n_chk++;
    if (dout_a[0] !== 4'hA) begin
      n_fail++;
      $display("FAIL reclear_data got=%h exp=a", dout_a[0]);
    end
    step();
    n_chk++;
    if (dout_a[3] !== 4'hA) begin
      n_fail++;
      $display("FAIL reclear_data_pipe got=%h exp=a", dout_a[3]);
    end
  endtask

  task automatic test_parity();
    wr(8'h50, 4'h7, 1'b1);
    rd(8'h50);
    n_chk++;
    if (dout_a[0] !== 4'h7 || perr_a[0] !== EXP_INJ_PERR) begin
      n_fail++;
      $display("FAIL perr_inj dout=%h perr=%b exp 7/%b", dout_a[0], perr_a[0], EXP_INJ_PERR);
    end
    step();
    n_chk++;
    if (dout_a[3] !== 4'h7 || perr_a[3] !== EXP_INJ_PERR) begin
      n_fail++;
      $display("FAIL perr_inj_pipe dout=%h perr=%b exp 7/%b", dout_a[3], perr_a[3], EXP_INJ_PERR);
    end
    wr(8'h50, 4'h7, 1'b0);
    rd(8'h50);
    n_chk++;
    if (dout_a[0] !== 4'h7 || perr_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_clean dout=%h perr=%b exp 7/0", dout_a[0], perr_a[0]);
    end
    step();
    n_chk++;
    if (perr_a[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_clean_pipe perr=%b exp 0", perr_a[3]);
    end
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b0; oce = 1'b1; wre = 1'b0; clr_req = 1'b0;
    perr_inj = 1'b0; ad = '0; din = '0;
    test_reset();
    test_rw();
    test_write_modes();
    test_pipeline();
    test_clr_restart();
    test_clear_reset();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
